l2cache_control: RTL and testbench

//  Control FSM for the 2-way set-associative L2 cache. Initiator/writer side of the tag, valid,

---
 rtl/l2cache_types_pkg.sv | 26 ++
 rtl/l2cache_hit_detect.sv | 22 ++
 rtl/l2cache_control.sv | 142 ++++++++++++++
 tb/tb_l2cache_control.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2cache_types_pkg.sv
// Shared types and address helpers for the L2 cache controller.
// Defaults describe a 32 B line, 8-set, 2-way cache.
package l2cache_types_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        WRITEBACK,
        FILL
    } state_t;

    typedef logic way_t;

    function automatic logic [S_INDEX-1:0] addr_index(input logic [31:0] addr);
        return addr[S_OFFSET +: S_INDEX];
    endfunction

    function automatic logic [S_TAG-1:0] addr_tag(input logic [31:0] addr);
        return addr[31 -: S_TAG];
    endfunction

endpackage

// File: rtl/l2cache_hit_detect.sv
// Two-way tag compare.
// Way0 takes priority if both ways ever match.
module l2cache_hit_detect
    import l2cache_types_pkg::*;
#(
    parameter int s_tag = S_TAG
) (
    input  logic [2*s_tag-1:0] tag_out,
    input  logic [1:0]         valid_out,
    input  logic [s_tag-1:0]   req_tag,
    output logic               hit,
    output way_t               hit_way
);

    logic [1:0] match;

    assign match[0] = valid_out[0] & (tag_out[s_tag-1:0] == req_tag);
    assign match[1] = valid_out[1] & (tag_out[2*s_tag-1:s_tag] == req_tag);
    assign hit      = |match;
    assign hit_way  = ~match[0];

endmodule

// File: rtl/l2cache_control.sv
// L2 cache control FSM: hit, victim writeback and line fill.
// Drives the tag/valid/dirty/LRU arrays and the pmem handshake.
module l2cache_control
    import l2cache_types_pkg::*;
#(
    parameter int s_offset = S_OFFSET,
    parameter int s_index  = S_INDEX
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          mem_address,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic                 pmem_addr_sel,
    input  logic [2*(32-s_offset-s_index)-1:0] tag_out,
    input  logic [1:0]           valid_out,
    input  logic [1:0]           dirty_out,
    input  logic                 lru_out,
    output logic                 array_read,
    output logic [s_index-1:0]   rindex,
    output logic [s_index-1:0]   windex,
    output logic [1:0]           tag_load,
    output logic [1:0]           valid_load,
    output logic [1:0]           dirty_load,
    output logic                 dirty_in,
    output logic                 lru_load,
    output logic                 lru_in,
    output logic [1:0]           data_load,
    output logic                 data_src,
    output logic                 data_way
);

    localparam int s_tag = 32 - s_offset - s_index;

    state_t state, next_state;
    way_t   victim;
    logic   hit;
    way_t   hit_way;
    logic   req;
    logic   unused_offset;

    assign req           = mem_read | mem_write;
    assign unused_offset = ^mem_address[s_offset-1:0];

    l2cache_hit_detect #(.s_tag(s_tag)) u_hit (
        .tag_out   (tag_out),
        .valid_out (valid_out),
        .req_tag   (mem_address[31:s_offset+s_index]),
        .hit       (hit),
        .hit_way   (hit_way)
    );

    // State register; reset returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Victim way is captured from LRU on the miss cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            victim <= 1'b0;
        else if (state == CHECK && req && !hit)
            victim <= lru_out;
    end

    // Next state and all outputs; everything stays 0 while reset is held.
    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        array_read    = 1'b0;
        rindex        = '0;
        windex        = '0;
        tag_load      = 2'b00;
        valid_load    = 2'b00;
        dirty_load    = 2'b00;
        dirty_in      = 1'b0;
        lru_load      = 1'b0;
        lru_in        = 1'b0;
        data_load     = 2'b00;
        data_src      = 1'b0;
        data_way      = 1'b0;
        if (!rst) begin
            rindex = mem_address[s_offset +: s_index];
            windex = mem_address[s_offset +: s_index];
            unique case (state)
                IDLE: begin
                    array_read = 1'b1;
                    if (req) next_state = CHECK;
                end
                CHECK: begin
                    array_read = 1'b1;
                    if (!req) begin
                        next_state = IDLE;
                    end else if (hit) begin
                        mem_resp   = 1'b1;
                        data_way   = hit_way;
                        lru_load   = 1'b1;
                        lru_in     = ~hit_way;
                        next_state = IDLE;
                        if (mem_write) begin
                            dirty_load[hit_way] = 1'b1;
                            dirty_in            = 1'b1;
                            data_load[hit_way]  = 1'b1;
                        end
                    end else if (valid_out[lru_out] & dirty_out[lru_out]) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    data_way      = victim;
                    if (pmem_resp) next_state = FILL;
                end
                FILL: begin
                    pmem_read = 1'b1;
                    data_way  = victim;
                    if (pmem_resp) begin
                        tag_load[victim]   = 1'b1;
                        valid_load[victim] = 1'b1;
                        dirty_load[victim] = 1'b1;
                        data_load[victim]  = 1'b1;
                        data_src           = 1'b1;
                        next_state         = CHECK;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2cache_control.sv
// Bench for l2cache_control with register-array and 3-cycle pmem models.
module tb_l2cache_control;

    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write;
    logic [31:0]   mem_address;
    logic          mem_resp, pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
    logic [2*TW-1:0] tag_out;
    logic [1:0]    valid_out, dirty_out;
    logic          lru_out, array_read;
    logic [2:0]    rindex, windex;
    logic [1:0]    tag_load, valid_load, dirty_load, data_load;
    logic          dirty_in, lru_load, lru_in, data_src, data_way;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    l2cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .pmem_addr_sel(pmem_addr_sel),
        .tag_out(tag_out), .valid_out(valid_out),
        .dirty_out(dirty_out), .lru_out(lru_out),
        .array_read(array_read), .rindex(rindex), .windex(windex),
        .tag_load(tag_load), .valid_load(valid_load),
        .dirty_load(dirty_load), .dirty_in(dirty_in),
        .lru_load(lru_load), .lru_in(lru_in),
        .data_load(data_load), .data_src(data_src), .data_way(data_way)
    );

    // Environment register arrays
    logic [TW-1:0] a_tag [8][2];
    logic [1:0]    a_valid [8];
    logic [1:0]    a_dirty [8];
    logic          a_lru [8];

    assign tag_out   = {a_tag[rindex][1], a_tag[rindex][0]};
    assign valid_out = a_valid[rindex];
    assign dirty_out = a_dirty[rindex];
    assign lru_out   = a_lru[rindex];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 8; s++) begin
                a_tag[s][0] <= '0;
                a_tag[s][1] <= '0;
                a_valid[s]  <= 2'b00;
                a_dirty[s]  <= 2'b00;
                a_lru[s]    <= 1'b0;
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (tag_load[w])   a_tag[windex][w]   <= mem_address[31:8];
                if (valid_load[w]) a_valid[windex][w] <= 1'b1;
                if (dirty_load[w]) a_dirty[windex][w] <= dirty_in;
            end
            if (lru_load) a_lru[windex] <= lru_in;
        end
    end

    // Physical memory: resp in the third cycle of a held request
    logic [1:0] pcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt      <= 2'd0;
            pmem_resp <= 1'b0;
        end else if (!(pmem_read | pmem_write) || pmem_resp) begin
            pcnt      <= 2'd0;
            pmem_resp <= 1'b0;
        end else begin
            pcnt      <= pcnt + 2'd1;
            pmem_resp <= (pcnt == 2'd1);
        end
    end

    // Reference model of cache contents
    int m_tag [8][2];
    bit m_valid [8][2];
    bit m_dirty [8][2];
    int m_lru [8];

    task automatic model_clear();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_tag[s][w] = 0; m_valid[s][w] = 0; m_dirty[s][w] = 0;
            end
            m_lru[s] = 0;
        end
    endtask

    task automatic model_access(input logic [31:0] a, input bit wr,
                                output int cyc, output int rdc,
                                output int wrc, output int way);
        int s, t;
        s = int'((a >> 5) % 8);
        t = int'(a >> 8);
        if (m_valid[s][0] && m_tag[s][0] == t)      way = 0;
        else if (m_valid[s][1] && m_tag[s][1] == t) way = 1;
        else                                        way = -1;
        rdc = 0; wrc = 0; cyc = 2;
        if (way < 0) begin
            way = m_lru[s];
            rdc = 3;
            wrc = (m_valid[s][way] && m_dirty[s][way]) ? 3 : 0;
            cyc = 6 + wrc;
            m_tag[s][way] = t; m_valid[s][way] = 1; m_dirty[s][way] = 0;
        end
        m_lru[s] = 1 - way;
        if (wr) m_dirty[s][way] = 1;
    endtask

    task automatic do_req(input logic [31:0] a, input bit wr,
                          output int cyc, output int rdc, output int wrc,
                          output int bad, output int dway,
                          output logic [1:0] dload, output logic dsrc);
        @(negedge clk);
        mem_address = a; mem_read = !wr; mem_write = wr;
        cyc = 0; rdc = 0; wrc = 0; bad = 0; dway = -1;
        dload = 2'bxx; dsrc = 1'bx;
        for (int i = 0; i < 40; i++) begin
            #1;
            cyc++;
            if (pmem_read) rdc++;
            if (pmem_write) wrc++;
            if (pmem_read && pmem_write) bad++;
            if (pmem_read && pmem_addr_sel) bad++;
            if (pmem_write && !pmem_addr_sel) bad++;
            if (mem_resp) begin
                dway = int'(data_way); dload = data_load; dsrc = data_src;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_read = 0; mem_write = 0; mem_address = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if ({mem_resp, pmem_read, pmem_write, pmem_addr_sel, array_read,
             rindex, windex, tag_load, valid_load, dirty_load, dirty_in,
             lru_load, lru_in, data_load, data_src, data_way} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got nonzero, resp=%b pr=%b pw=%b ar=%b want all 0",
                     mem_resp, pmem_read, pmem_write, array_read);
        end
        @(negedge clk); rst = 1'b0; #1;
        n_cmp++;
        if ({array_read, pmem_read, pmem_write, mem_resp} !== 4'b1000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b want 1000",
                     {array_read, pmem_read, pmem_write, mem_resp});
        end
        model_clear();
    endtask

    task automatic test_directed();
        logic [31:0] addrs [5] = '{32'h40, 32'h40, 32'h140, 32'h240, 32'h340};
        bit          wrs   [5] = '{0, 0, 1, 0, 0};
        int          ecyc  [5] = '{6, 2, 6, 6, 9};
        int          eway  [5] = '{0, 0, 1, 0, 1};
        int cyc, rdc, wrc, bad, dway, mc, mr, mw, mway, s;
        logic [1:0] dload;
        logic dsrc;
        for (int i = 0; i < 5; i++) begin
            model_access(addrs[i], wrs[i], mc, mr, mw, mway);
            do_req(addrs[i], wrs[i], cyc, rdc, wrc, bad, dway, dload, dsrc);
            s = 2;
            n_cmp++;
            if (cyc !== ecyc[i] || dway !== eway[i]) begin
                n_bad++;
                $display("FAIL dir%0d_latency_way: got cyc=%0d way=%0d want cyc=%0d way=%0d",
                         i, cyc, dway, ecyc[i], eway[i]);
            end
            n_cmp++;
            if (rdc !== mr || wrc !== mw || bad !== 0) begin
                n_bad++;
                $display("FAIL dir%0d_pmem: got rd=%0d wr=%0d bad=%0d want rd=%0d wr=%0d bad=0",
                         i, rdc, wrc, bad, mr, mw);
            end
            n_cmp++;
            if (dload !== (wrs[i] ? 2'(1 << mway) : 2'b00) || dsrc !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d_data_load: got %b/%b want %b/0",
                         i, dload, dsrc, wrs[i] ? 2'(1 << mway) : 2'b00);
            end
            n_cmp++;
            if ({a_valid[s], a_dirty[s], a_lru[s]} !==
                {m_valid[s][1], m_valid[s][0], m_dirty[s][1], m_dirty[s][0], m_lru[s][0]}) begin
                n_bad++;
                $display("FAIL dir%0d_array_state: got v=%b d=%b l=%b want v=%b%b d=%b%b l=%0d",
                         i, a_valid[s], a_dirty[s], a_lru[s], m_valid[s][1], m_valid[s][0],
                         m_dirty[s][1], m_dirty[s][0], m_lru[s]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        int resps = 0;
        @(negedge clk);
        mem_address = 32'h7E0; mem_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pmem_read) begin seen = 1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL midrst_fill_start: got no pmem_read want pmem_read=1");
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({pmem_read, pmem_write, mem_resp, array_read} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_drop: got %b want 0000",
                     {pmem_read, pmem_write, mem_resp, array_read});
        end
        @(negedge clk); rst = 1'b0; mem_read = 1'b0; #1;
        n_cmp++;
        if ({array_read, pmem_read, pmem_write} !== 3'b100) begin
            n_bad++;
            $display("FAIL midrst_idle: got %b want 100", {array_read, pmem_read, pmem_write});
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (mem_resp || pmem_read) resps++;
        end
        n_cmp++;
        if (resps !== 0) begin
            n_bad++;
            $display("FAIL midrst_quiet: got %0d active cycles want 0", resps);
        end
        model_clear();
    endtask

    task automatic test_random();
        int cyc, rdc, wrc, bad, dway, mc, mr, mw, mway, s;
        logic [1:0] dload;
        logic dsrc;
        logic [31:0] a;
        bit wr;
        for (int i = 0; i < 60; i++) begin
            s  = int'($urandom_range(0, 3));
            a  = ($urandom_range(0, 5) << 8) | (s << 5) | $urandom_range(0, 31);
            wr = 1'($urandom_range(0, 1));
            model_access(a, wr, mc, mr, mw, mway);
            do_req(a, wr, cyc, rdc, wrc, bad, dway, dload, dsrc);
            n_cmp++;
            if (cyc !== mc || dway !== mway) begin
                n_bad++;
                $display("FAIL rnd%0d_latency_way a=%h: got cyc=%0d way=%0d want cyc=%0d way=%0d",
                         i, a, cyc, dway, mc, mway);
            end
            n_cmp++;
            if (rdc !== mr || wrc !== mw || bad !== 0) begin
                n_bad++;
                $display("FAIL rnd%0d_pmem a=%h: got rd=%0d wr=%0d bad=%0d want rd=%0d wr=%0d bad=0",
                         i, a, rdc, wrc, bad, mr, mw);
            end
            n_cmp++;
            if (dload !== (wr ? 2'(1 << mway) : 2'b00) || dsrc !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd%0d_data_load: got %b/%b want %b/0",
                         i, dload, dsrc, wr ? 2'(1 << mway) : 2'b00);
            end
            n_cmp++;
            if ({a_valid[s], a_dirty[s], a_lru[s]} !==
                {m_valid[s][1], m_valid[s][0], m_dirty[s][1], m_dirty[s][0], m_lru[s][0]} ||
                int'(a_tag[s][mway]) !== m_tag[s][mway]) begin
                n_bad++;
                $display("FAIL rnd%0d_array_state: got v=%b d=%b l=%b t=%h want v=%b%b d=%b%b l=%0d t=%h",
                         i, a_valid[s], a_dirty[s], a_lru[s], a_tag[s][mway],
                         m_valid[s][1], m_valid[s][0], m_dirty[s][1], m_dirty[s][0],
                         m_lru[s], m_tag[s][mway]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
